// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM port arbiter
package sram_arb_pkg;

    // Which requester owns the read data returning from the SRAM this cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam logic [3:0] BMASK_FULL = 4'hF;
    localparam int         WORD_SHIFT = 2;

    // Expand a 4-bit byte-lane enable into a 32-bit AND mask
    function automatic logic [31:0] lane_mask(input logic [3:0] bmask);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{bmask[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - IF/LS arbiter for a single-port byte-masked SRAM
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [DW-1:0] o_if_rdata,

    input  logic          i_ls_req,
    input  logic          i_ls_wren,
    input  logic [AW-1:0] i_ls_addr,
    input  logic [DW-1:0] i_ls_wdata,
    input  logic [3:0]    i_ls_bmask,
    output logic          o_ls_gnt,
    output logic          o_ls_rvalid,
    output logic [DW-1:0] o_ls_rdata,

    output logic          o_mem_cs,
    output logic          o_mem_wren,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic [3:0]    o_mem_bmask,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    owner_e     owner_q,      owner_d;
    logic [3:0] rd_mask_q,    rd_mask_d;

    logic if_gnt;
    logic ls_gnt;
    logic if_forced;

    // IF has waited long enough; it takes the port even if LS is asking
    assign if_forced = i_if_req && (starve_cnt_q == STARVE_LIM);

    // Grant selection: LS first, unless IF has hit the starvation limit
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!i_reset) begin
            if (if_forced) begin
                if_gnt = 1'b1;
            end else if (i_ls_req) begin
                ls_gnt = 1'b1;
            end else if (i_if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    assign o_if_gnt = if_gnt;
    assign o_ls_gnt = ls_gnt;

    // SRAM command drive from the winner; idle lines parked at zero
    always_comb begin
        o_mem_cs    = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = 4'h0;
        if (ls_gnt) begin
            o_mem_cs    = 1'b1;
            o_mem_wren  = i_ls_wren;
            o_mem_addr  = i_ls_addr >> WORD_SHIFT;
            o_mem_wdata = i_ls_wdata;
            o_mem_bmask = i_ls_bmask;
        end else if (if_gnt) begin
            o_mem_cs    = 1'b1;
            o_mem_addr  = i_if_addr >> WORD_SHIFT;
            o_mem_bmask = BMASK_FULL;
        end
    end

    // Starvation counter: count denied IF cycles, saturate, clear on grant or idle
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_if_req || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Response owner next state: whoever issued a read this cycle owns next cycle's data
    always_comb begin
        owner_d   = OWN_NONE;
        rd_mask_d = 4'h0;
        if (if_gnt) begin
            owner_d   = OWN_IF;
            rd_mask_d = BMASK_FULL;
        end else if (ls_gnt && !i_ls_wren) begin
            owner_d   = OWN_LS;
            rd_mask_d = i_ls_bmask;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            starve_cnt_q <= 4'd0;
            owner_q      <= OWN_NONE;
            rd_mask_q    <= 4'h0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            rd_mask_q    <= rd_mask_d;
        end
    end

    // Response routing; gated by reset so a read in flight when reset arrives is dropped
    always_comb begin
        o_if_rvalid = (owner_q == OWN_IF) && !i_reset;
        o_ls_rvalid = (owner_q == OWN_LS) && !i_reset;
        o_if_rdata  = '0;
        o_ls_rdata  = '0;
        if (o_if_rvalid) begin
            o_if_rdata = i_mem_rdata;
        end
        if (o_ls_rvalid) begin
            o_ls_rdata = i_mem_rdata & DW'(lane_mask(rd_mask_q));
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_wren;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_bmask;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_cs, mem_wren;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_bmask;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        bit          is_ls;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    sram_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_ls_req    (ls_req),
        .i_ls_wren   (ls_wren),
        .i_ls_addr   (ls_addr),
        .i_ls_wdata  (ls_wdata),
        .i_ls_bmask  (ls_bmask),
        .o_ls_gnt    (ls_gnt),
        .o_ls_rvalid (ls_rvalid),
        .o_ls_rdata  (ls_rdata),
        .o_mem_cs    (mem_cs),
        .o_mem_wren  (mem_wren),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_bmask (mem_bmask),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read, byte-masked write
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wren) begin
                for (int k = 0; k < 4; k++)
                    if (mem_bmask[k]) mem[mem_addr[7:0]][8*k +: 8] <= mem_wdata[8*k +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[7:0]];
            end
        end
    end

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{m[k]}};
        return r;
    endfunction

    // Response scoreboard: every negedge, both ports must match the due entry (or be idle)
    logic        e_if_v, e_ls_v;
    logic [31:0] e_if_d, e_ls_d;
    exp_t        e;
    always @(negedge clk) begin
        e_if_v = 1'b0; e_ls_v = 1'b0; e_if_d = '0; e_ls_d = '0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (e.is_ls) begin e_ls_v = 1'b1; e_ls_d = e.data; end
            else         begin e_if_v = 1'b1; e_if_d = e.data; end
        end
        n_checks++;
        if ({if_rvalid, ls_rvalid} !== {e_if_v, e_ls_v}) begin
            n_fail++;
            $display("FAIL rvalid cyc=%0d actual if/ls=%b%b required=%b%b", cyc, if_rvalid, ls_rvalid, e_if_v, e_ls_v);
        end
        n_checks++;
        if (if_rdata !== e_if_d) begin
            n_fail++;
            $display("FAIL if_rdata cyc=%0d actual=%h required=%h", cyc, if_rdata, e_if_d);
        end
        n_checks++;
        if (ls_rdata !== e_ls_d) begin
            n_fail++;
            $display("FAIL ls_rdata cyc=%0d actual=%h required=%h", cyc, ls_rdata, e_ls_d);
        end
    end

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wren = 1'b0; ls_addr = '0; ls_wdata = '0; ls_bmask = 4'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h8;
        ls_req = 1'b1; ls_addr = 32'hC; ls_bmask = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({if_gnt, ls_gnt, mem_cs, mem_wren} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_grants actual=%b required=0000", {if_gnt, ls_gnt, mem_cs, mem_wren});
            end
            next_cycle();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_if_read();
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL if_read_gnt actual=%b required=10", {if_gnt, ls_gnt});
        end
        n_checks++;
        if ({mem_cs, mem_wren, mem_addr, mem_bmask, mem_wdata} !== {1'b1, 1'b0, 32'h4, 4'hF, 32'h0}) begin
            n_fail++;
            $display("FAIL if_read_drive actual cs=%b wr=%b addr=%h bm=%h wd=%h required 1 0 00000004 f 00000000",
                     mem_cs, mem_wren, mem_addr, mem_bmask, mem_wdata);
        end
        sbq.push_back('{cyc + 1, 1'b0, ref_mem[4]});
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_ls_write_read();
        ls_req = 1'b1; ls_wren = 1'b1; ls_addr = 32'h20; ls_wdata = 32'hAABBCCDD; ls_bmask = 4'b0011;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, ls_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL ls_write_gnt actual=%b required=01", {if_gnt, ls_gnt});
        end
        n_checks++;
        if ({mem_cs, mem_wren, mem_addr, mem_bmask, mem_wdata} !== {1'b1, 1'b1, 32'h8, 4'h3, 32'hAABBCCDD}) begin
            n_fail++;
            $display("FAIL ls_write_drive actual cs=%b wr=%b addr=%h bm=%h wd=%h required 1 1 00000008 3 aabbccdd",
                     mem_cs, mem_wren, mem_addr, mem_bmask, mem_wdata);
        end
        ref_mem[8][7:0]  = 8'hDD;
        ref_mem[8][15:8] = 8'hCC;
        next_cycle();
        ls_wren = 1'b0; ls_wdata = '0;
        @(negedge clk);
        n_checks++;
        if ({ls_gnt, mem_cs, mem_wren} !== 3'b110) begin
            n_fail++;
            $display("FAIL ls_read_gnt actual=%b required=110", {ls_gnt, mem_cs, mem_wren});
        end
        sbq.push_back('{cyc + 1, 1'b1, ref_mem[8] & expand(4'b0011)});
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (ls_rdata !== 32'h0000CCDD) begin
            n_fail++;
            $display("FAIL ls_write_read_data actual=%h required=0000ccdd", ls_rdata);
        end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        int cnt = 0;
        logic exp_if;
        if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b1; ls_wren = 1'b0; ls_addr = 32'h44; ls_bmask = 4'hF;
        for (int i = 0; i < 10; i++) begin
            exp_if = (cnt == 4);
            @(negedge clk);
            n_checks++;
            if ({if_gnt, ls_gnt} !== {exp_if, !exp_if}) begin
                n_fail++;
                $display("FAIL simul_gnt cycle=%0d actual=%b required=%b", i, {if_gnt, ls_gnt}, {exp_if, !exp_if});
            end
            n_checks++;
            if (mem_addr !== (exp_if ? 32'h10 : 32'h11)) begin
                n_fail++;
                $display("FAIL simul_addr cycle=%0d actual=%h required=%h", i, mem_addr, exp_if ? 32'h10 : 32'h11);
            end
            if (exp_if) sbq.push_back('{cyc + 1, 1'b0, ref_mem[16]});
            else        sbq.push_back('{cyc + 1, 1'b1, ref_mem[17]});
            cnt = exp_if ? 0 : ((cnt < 4) ? cnt + 1 : cnt);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] masks [4] = '{4'hF, 4'b0101, 4'b1000, 4'b0110};
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                if_req = 1'b1; if_addr = 32'(4 * (i + 2)) + 32'(i % 4);
            end else begin
                ls_req = 1'b1; ls_addr = 32'(4 * (i + 40)); ls_bmask = masks[i % 4];
            end
            @(negedge clk);
            n_checks++;
            if ({if_gnt, ls_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL b2b_gnt cycle=%0d actual=%b required=%b", i, {if_gnt, ls_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (i % 2 == 0) sbq.push_back('{cyc + 1, 1'b0, ref_mem[i + 2]});
            else            sbq.push_back('{cyc + 1, 1'b1, ref_mem[i + 40] & expand(masks[i % 4])});
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        int cnt = 0;
        logic exp_if;
        if_req = 1'b1; if_addr = 32'h60;
        ls_req = 1'b1; ls_wren = 1'b0; ls_addr = 32'h30; ls_bmask = 4'b1100;
        // three LS wins build up the IF starvation count; the third read is cut by reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({if_gnt, ls_gnt} !== 2'b01) begin
                n_fail++;
                $display("FAIL pre_reset_gnt cycle=%0d actual=%b required=01", i, {if_gnt, ls_gnt});
            end
            if (i < 2) sbq.push_back('{cyc + 1, 1'b1, ref_mem[12] & expand(4'b1100)});
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, ls_gnt, mem_cs, ls_rvalid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset actual=%b required=0000", {if_gnt, ls_gnt, mem_cs, ls_rvalid});
        end
        next_cycle();
        reset = 1'b0;
        // a cleared counter gives LS four wins before IF is forced through
        for (int i = 0; i < 6; i++) begin
            exp_if = (cnt == 4);
            @(negedge clk);
            n_checks++;
            if ({if_gnt, ls_gnt} !== {exp_if, !exp_if}) begin
                n_fail++;
                $display("FAIL post_reset_gnt cycle=%0d actual=%b required=%b", i, {if_gnt, ls_gnt}, {exp_if, !exp_if});
            end
            if (i == 0) begin
                n_checks++;
                if (ls_rvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_reset_rvalid actual=%b required=0", ls_rvalid);
                end
            end
            if (exp_if) sbq.push_back('{cyc + 1, 1'b0, ref_mem[24]});
            else        sbq.push_back('{cyc + 1, 1'b1, ref_mem[12] & expand(4'b1100)});
            cnt = exp_if ? 0 : ((cnt < 4) ? cnt + 1 : cnt);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({if_gnt, ls_gnt, mem_cs, mem_wren, mem_addr, mem_wdata, mem_bmask, if_rvalid, ls_rvalid} !== '0) begin
                n_fail++;
                $display("FAIL idle cycle=%0d actual gnt=%b%b cs=%b wr=%b addr=%h wd=%h bm=%h rv=%b%b required all zero",
                         i, if_gnt, ls_gnt, mem_cs, mem_wren, mem_addr, mem_wdata, mem_bmask, if_rvalid, ls_rvalid);
            end
            next_cycle();
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 32'h12345678 ^ (32'(i) * 32'h01010101);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        mem_rdata = '0;
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        test_reset();
        test_idle();
        test_if_read();
        test_ls_write_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_read();
        test_idle();
        next_cycle();
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
